// File: rtl/chord_song_reader_pkg.sv
// rtl/chord_song_reader_pkg.sv - shared entry codes, field positions and FSM encoding
package chord_song_reader_pkg;

   // Entry type codes held in the top two bits of a ROM word (1x is end)
   localparam logic [1:0] ENTRY_NOTE = 2'b00;
   localparam logic [1:0] ENTRY_ADV  = 2'b01;
   localparam logic [1:0] ENTRY_END  = 2'b10;

   // Field bit positions within a 16-bit ROM word
   localparam int TYPE_HI = 15;
   localparam int TYPE_LO = 14;
   localparam int NOTE_HI = 11;
   localparam int NOTE_LO = 6;
   localparam int DUR_HI  = 5;
   localparam int DUR_LO  = 0;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      FETCH       = 3'd1,
      DECODE      = 3'd2,
      WAIT_PLAYER = 3'd3,
      HOLD        = 3'd4,
      WAIT_BEATS  = 3'd5,
      DONE        = 3'd6
   } state_t;

   function automatic logic [15:0] make_note(input logic [5:0] n, input logic [5:0] d);
      return {ENTRY_NOTE, 2'b00, n, d};
   endfunction

   function automatic logic [15:0] make_adv(input logic [5:0] beats);
      return {ENTRY_ADV, 8'h00, beats};
   endfunction

   function automatic logic [15:0] make_end();
      return {ENTRY_END, 14'h0000};
   endfunction

endpackage

// File: rtl/chord_song_reader_song_rom.sv
// rtl/chord_song_reader_song_rom.sv - synchronous-read song ROM addressed by {song, idx}
import chord_song_reader_pkg::*;

module song_rom #(
   parameter int SONG_W = 2,
   parameter int IDX_W  = 5
) (
   input  logic              clk,
   input  logic [SONG_W-1:0] song,
   input  logic [IDX_W-1:0]  idx,
   output logic [15:0]       data
);

   // Song 0: short chord then a rest; song 1: two notes, a zero advance, a
   // long advance and one more note; song 2: every slot a note, no end entry
   function automatic logic [15:0] rom_word(input int s, input int i);
      logic [15:0] w;
      w = make_end();
      case (s)
         0: case (i)
               0: w = make_note(6'd20, 6'd8);
               1: w = make_note(6'd24, 6'd8);
               2: w = make_note(6'd27, 6'd8);
               3: w = make_adv(6'd8);
               default: w = make_end();
            endcase
         1: case (i)
               0: w = make_note(6'd40, 6'd4);
               1: w = make_note(6'd43, 6'd4);
               2: w = make_adv(6'd0);
               3: w = make_adv(6'd12);
               4: w = make_note(6'd47, 6'd2);
               default: w = make_end();
            endcase
         2: w = make_note(6'(i + 1), 6'd3);
         default: w = make_end();
      endcase
      return w;
   endfunction

   // Registered read: data is valid the cycle after the address is presented
   always_ff @(posedge clk) begin
      data <= rom_word(int'(song), int'(idx));
   end

endmodule

// File: rtl/chord_song_reader.sv
// rtl/chord_song_reader.sv - song ROM sequencer feeding the chord engine (option: CHORD_SONG_LOOP_EN)
import chord_song_reader_pkg::*;

module chord_song_reader #(
   parameter int SONG_W  = 2,
   parameter int IDX_W   = 5,
   parameter int HOLDOFF = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic [SONG_W-1:0] song,
   input  logic              player_available,
   input  logic              beat,
   output logic              new_note,
   output logic [5:0]        note_to_load,
   output logic [5:0]        duration_to_load,
   output logic              song_done
);

`ifdef CHORD_SONG_LOOP_EN
   localparam state_t END_STATE  = FETCH;
   localparam state_t LAST_NOTE  = HOLD;
`else
   localparam state_t END_STATE  = DONE;
   localparam state_t LAST_NOTE  = DONE;
`endif

   state_t            state_q, state_d;
   logic [SONG_W-1:0] song_q;
   logic [IDX_W-1:0]  idx_q;
   logic [5:0]        beat_cnt_q;
   logic [7:0]        hold_cnt_q;
   logic [15:0]       rom_data;

   logic song_latch, idx_clr, idx_inc, beat_load, beat_dec;
   logic hold_clr, hold_inc, strobe, end_evt;

   wire [1:0] entry_type = rom_data[TYPE_HI:TYPE_LO];
   wire [5:0] adv_cnt    = rom_data[DUR_HI:DUR_LO];
   wire       song_chg   = (song != song_q);
   wire       idx_last   = &idx_q;
   wire       hold_last  = (hold_cnt_q == 8'(HOLDOFF - 1));
   wire       unused_bits = ^rom_data[13:12];
   // An increment past the last index ends (or loops) the song
   wire state_t step_state = idx_last ? END_STATE : FETCH;

   song_rom #(.SONG_W(SONG_W), .IDX_W(IDX_W)) u_rom (
      .clk  (clk),
      .song (song_q),
      .idx  (idx_q),
      .data (rom_data)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state: song change beats pause, pause freezes every running state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (play) state_d = FETCH;
         DONE: if (!play || song_chg) state_d = IDLE;
         default: begin
            if (song_chg) begin
               state_d = FETCH;
            end else if (play) begin
               case (state_q)
                  FETCH:  state_d = DECODE;
                  DECODE: begin
                     case (entry_type)
                        ENTRY_NOTE: state_d = WAIT_PLAYER;
                        ENTRY_ADV:  state_d = (adv_cnt == 6'd0) ? step_state : WAIT_BEATS;
                        default:    state_d = END_STATE;
                     endcase
                  end
                  WAIT_PLAYER: if (player_available) state_d = idx_last ? LAST_NOTE : HOLD;
                  HOLD:        if (hold_last) state_d = FETCH;
                  WAIT_BEATS:  if (beat && beat_cnt_q == 6'd1) state_d = step_state;
                  default:     state_d = state_q;
               endcase
            end
         end
      endcase
   end

   // Datapath controls decoded from the current state and inputs
   always_comb begin
      song_latch = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      beat_load  = 1'b0;
      beat_dec   = 1'b0;
      hold_clr   = 1'b0;
      hold_inc   = 1'b0;
      strobe     = 1'b0;
      end_evt    = 1'b0;
      case (state_q)
         IDLE: if (play) begin
            song_latch = 1'b1;
            idx_clr    = 1'b1;
         end
         DONE: ;
         default: begin
            if (song_chg) begin
               song_latch = 1'b1;
               idx_clr    = 1'b1;
            end else if (play) begin
               case (state_q)
                  DECODE: begin
                     case (entry_type)
                        ENTRY_NOTE: ;
                        ENTRY_ADV: begin
                           if (adv_cnt == 6'd0) begin
                              idx_inc = 1'b1;
                              end_evt = idx_last;
                           end else begin
                              beat_load = 1'b1;
                           end
                        end
                        default: begin
                           idx_clr = 1'b1;
                           end_evt = 1'b1;
                        end
                     endcase
                  end
                  WAIT_PLAYER: if (player_available) begin
                     strobe   = 1'b1;
                     idx_inc  = 1'b1;
                     hold_clr = 1'b1;
                     end_evt  = idx_last;
                  end
                  HOLD: hold_inc = 1'b1;
                  WAIT_BEATS: if (beat) begin
                     beat_dec = 1'b1;
                     if (beat_cnt_q == 6'd1) begin
                        idx_inc = 1'b1;
                        end_evt = idx_last;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // Counters, latched song and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         song_q           <= '0;
         idx_q            <= '0;
         beat_cnt_q       <= '0;
         hold_cnt_q       <= '0;
         new_note         <= 1'b0;
         note_to_load     <= '0;
         duration_to_load <= '0;
         song_done        <= 1'b0;
      end else begin
         if (song_latch) song_q <= song;
         if (idx_clr)      idx_q <= '0;
         else if (idx_inc) idx_q <= idx_q + 1'b1;
         if (beat_load)     beat_cnt_q <= adv_cnt;
         else if (beat_dec) beat_cnt_q <= beat_cnt_q - 6'd1;
         if (hold_clr)      hold_cnt_q <= '0;
         else if (hold_inc) hold_cnt_q <= hold_cnt_q + 8'd1;
         new_note <= strobe;
         if (strobe) begin
            note_to_load     <= rom_data[NOTE_HI:NOTE_LO];
            duration_to_load <= rom_data[DUR_HI:DUR_LO];
         end
`ifdef CHORD_SONG_LOOP_EN
         song_done <= end_evt;
`else
         song_done <= (state_d == DONE);
`endif
      end
   end

endmodule

// File: tb/tb_chord_song_reader.sv
// tb/tb_chord_song_reader.sv - scoreboard bench for chord_song_reader
import chord_song_reader_pkg::*;

module tb_chord_song_reader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       play = 1'b0;
   logic [1:0] song = 2'd0;
   logic       player_available = 1'b1;
   logic       beat = 1'b0;
   logic       new_note;
   logic [5:0] note_to_load;
   logic [5:0] duration_to_load;
   logic       song_done;

   typedef struct { int note; int dur; } exp_t;
   exp_t exp_q[$];
   int   strobe_t[$];
   int   strobe_cnt = 0;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   chord_song_reader #(.SONG_W(2), .IDX_W(5), .HOLDOFF(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .play             (play),
      .song             (song),
      .player_available (player_available),
      .beat             (beat),
      .new_note         (new_note),
      .note_to_load     (note_to_load),
      .duration_to_load (duration_to_load),
      .song_done        (song_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every strobe pops the next expected note
   always @(negedge clk) begin
      if (!reset && new_note === 1'b1) begin
         strobe_t.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("note", int'(note_to_load), e.note);
            chk("duration", int'(duration_to_load), e.dur);
         end
         strobe_cnt++;
      end
   end

   task automatic push(input int n, input int d);
      exp_t e;
      e.note = n;
      e.dur  = d;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_strobes(input int target, input int budget, input string tag);
      int b;
      b = 0;
      while (strobe_cnt < target && b < budget) begin
         @(negedge clk);
         #1;
         b++;
      end
      chk(tag, strobe_cnt, target);
   endtask

   task automatic pulse_beat(output int at);
      @(posedge clk);
      #1;
      beat = 1'b1;
      at = cyc;
      @(posedge clk);
      #1;
      beat = 1'b0;
   endtask

   initial begin
      int c0, n0, cp, b;

      // Reset state
      step(3);
      @(negedge clk);
      chk("rst_new_note", int'(new_note), 0);
      chk("rst_note", int'(note_to_load), 0);
      chk("rst_dur", int'(duration_to_load), 0);
      chk("rst_done", int'(song_done), 0);
      step(1);
      reset = 1'b0;
      step(2);

      // Song 0 chord: latency, spacing, beat wait, done
      push(20, 8); push(24, 8); push(27, 8);
      play = 1'b1;
      c0 = cyc;
      wait_strobes(3, 40, "chord_timeout");
      chk("first_latency", strobe_t[0] - c0, 4);
      chk("spacing_1", strobe_t[1] - strobe_t[0], 5);
      chk("spacing_2", strobe_t[2] - strobe_t[1], 5);
      step(10);
      chk("no_strobe_in_adv", strobe_cnt, 3);
      repeat (7) begin pulse_beat(b); step(1); end
      @(negedge clk);
      chk("done_before_8th", int'(song_done), 0);
      pulse_beat(b);
      step(5);
      @(negedge clk);
      chk("done_after_8th", int'(song_done), 1);
      chk("strobes_song0", strobe_cnt, 3);
      step(1);
      play = 1'b0;
      step(3);
      @(negedge clk);
      chk("done_cleared", int'(song_done), 0);

      // Voice starvation: held off until player_available returns
      step(1);
      player_available = 1'b0;
      push(20, 8); push(24, 8); push(27, 8);
      n0 = strobe_cnt;
      play = 1'b1;
      step(50);
      chk("starved_no_strobe", strobe_cnt, n0);
      player_available = 1'b1;
      cp = cyc;
      wait_strobes(n0 + 3, 40, "starve_timeout");
      chk("strobe_on_return", strobe_t[n0] - cp, 1);
      chk("starve_spacing", strobe_t[n0 + 1] - strobe_t[n0], 5);

      // Song switch while waiting for a voice
      reset = 1'b1;
      step(2);
      song = 2'd0;
      player_available = 1'b0;
      reset = 1'b0;
      step(1);
      n0 = strobe_cnt;
      step(6);
      push(40, 4); push(43, 4); push(47, 2);
      song = 2'd1;
      step(5);
      chk("switch_no_strobe", strobe_cnt, n0);
      player_available = 1'b1;
      wait_strobes(n0 + 2, 40, "switch_timeout");
      step(15);

      // Pause in the middle of a 12-beat advance
      repeat (7) begin pulse_beat(b); step(1); end
      play = 1'b0;
      repeat (10) begin pulse_beat(b); step(1); end
      step(5);
      chk("pause_no_strobe", strobe_cnt, n0 + 2);
      play = 1'b1;
      repeat (4) begin pulse_beat(b); step(1); end
      step(10);
      chk("resume_4_no_strobe", strobe_cnt, n0 + 2);
      pulse_beat(b);
      wait_strobes(n0 + 3, 20, "resume_timeout");
      chk("resume_latency", strobe_t[n0 + 2] - b, 4);
      step(8);
      @(negedge clk);
      chk("song1_done", int'(song_done), 1);

      // Asynchronous reset during HOLD
      play = 1'b0;
      song = 2'd0;
      step(3);
      n0 = strobe_cnt;
      push(20, 8);
      play = 1'b1;
      wait_strobes(n0 + 1, 20, "hold_timeout");
      reset = 1'b1;
      #1;
      chk("arst_new_note", int'(new_note), 0);
      chk("arst_note", int'(note_to_load), 0);
      chk("arst_dur", int'(duration_to_load), 0);
      chk("arst_done", int'(song_done), 0);
      chk("arst_state", int'(dut.state_q), int'(IDLE));
      step(2);
      push(20, 8); push(24, 8); push(27, 8);
      reset = 1'b0;
      wait_strobes(n0 + 4, 40, "replay_timeout");

      // 32 note entries with no end entry
      reset = 1'b1;
      step(2);
      song = 2'd2;
      for (int i = 0; i < 32; i++) push(i + 1, 3);
`ifdef CHORD_SONG_LOOP_EN
      push(1, 3);
`endif
      n0 = strobe_cnt;
      reset = 1'b0;
`ifdef CHORD_SONG_LOOP_EN
      wait_strobes(n0 + 33, 400, "loop_timeout");
`else
      wait_strobes(n0 + 32, 400, "wrap_timeout");
      step(10);
      @(negedge clk);
      chk("wrap_done", int'(song_done), 1);
      chk("wrap_no_extra", strobe_cnt, n0 + 32);
`endif
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   // Absolute bound so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout observed=%0d expected=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
